// File: rtl/ps2_voice_if.sv
// PS/2 byte stream in, voice allocation state and note events out.
interface ps2_voice_if #(parameter int unsigned NUM_VOICES = 4);
   logic [7:0]              ps2_key_data;
   logic                    ps2_key_pressed;
   logic [NUM_VOICES-1:0]   voice_active;
   logic [8*NUM_VOICES-1:0] voice_key;
   logic                    note_on;
   logic                    note_off;
   logic [2:0]              event_voice;
   logic [7:0]              event_code;
   logic                    voices_full;

   modport master (
      output ps2_key_data, ps2_key_pressed,
      input  voice_active, voice_key, note_on, note_off,
             event_voice, event_code, voices_full
   );

   modport slave (
      input  ps2_key_data, ps2_key_pressed,
      output voice_active, voice_key, note_on, note_off,
             event_voice, event_code, voices_full
   );
endinterface

// File: rtl/ps2_voice_scheduler.sv
// Set-2 scan-code decoder that shares a pool of voices among held keys.
// Optional: define VOICE_STEAL_EN to steal a voice round-robin when the pool is full.
module ps2_voice_scheduler #(
   parameter int unsigned NUM_VOICES = 4
) (
   input logic         CLOCK_50,
   input logic         reset,
   ps2_voice_if.slave  bus
);
   localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t                      state;
   logic [NUM_VOICES-1:0]       active;
   logic [NUM_VOICES-1:0][7:0]  keys;
   logic                        note_on_r;
   logic                        note_off_r;
   logic [2:0]                  ev_voice;
   logic [7:0]                  ev_code;
`ifdef VOICE_STEAL_EN
   logic [IW-1:0]               steal;
`endif

   logic          hit;
   logic [IW-1:0] hit_idx;
   logic          free;
   logic [IW-1:0] free_idx;
   logic [7:0]    data;

   assign data = bus.ps2_key_data;

   // Protocol/ack bytes from the keyboard that never carry a key.
   function automatic logic is_ignored(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
         default:                                                is_ignored = 1'b0;
      endcase
   endfunction

   // Descending scan so the lowest matching/free index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (active[v] && (keys[v] == data)) begin
            hit     = 1'b1;
            hit_idx = IW'(v);
         end
         if (!active[v]) begin
            free     = 1'b1;
            free_idx = IW'(v);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         active     <= '0;
         keys       <= '0;
         note_on_r  <= 1'b0;
         note_off_r <= 1'b0;
         ev_voice   <= '0;
         ev_code    <= '0;
`ifdef VOICE_STEAL_EN
         steal      <= '0;
`endif
      end else begin
         note_on_r  <= 1'b0;
         note_off_r <= 1'b0;
         if (bus.ps2_key_pressed) begin
            unique case (state)
               IDLE: begin
                  if (data == 8'hF0) begin
                     state <= BRK;
                  end else if (data == 8'hE0) begin
                     state <= EXT;
                  end else if (!is_ignored(data) && !hit) begin
                     if (free) begin
                        active[free_idx] <= 1'b1;
                        keys[free_idx]   <= data;
                        note_on_r        <= 1'b1;
                        ev_voice         <= 3'(free_idx);
                        ev_code          <= data;
                     end
`ifdef VOICE_STEAL_EN
                     else begin
                        keys[steal] <= data;
                        note_on_r   <= 1'b1;
                        note_off_r  <= 1'b1;
                        ev_voice    <= 3'(steal);
                        ev_code     <= data;
                        steal       <= (steal == IW'(NUM_VOICES - 1)) ? '0 : steal + IW'(1);
                     end
`endif
                  end
               end
               BRK: begin
                  state <= IDLE;
                  if (hit) begin
                     active[hit_idx] <= 1'b0;
                     note_off_r      <= 1'b1;
                     ev_voice        <= 3'(hit_idx);
                     ev_code         <= data;
                  end
               end
               EXT:     state <= (data == 8'hF0) ? EXT_BRK : IDLE;
               EXT_BRK: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.voice_active = active;
   assign bus.voice_key    = keys;
   assign bus.note_on      = note_on_r;
   assign bus.note_off     = note_off_r;
   assign bus.event_voice  = ev_voice;
   assign bus.event_code   = ev_code;
   assign bus.voices_full  = &active;
endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Directed bench for ps2_voice_scheduler with NUM_VOICES=4.
module tb_ps2_voice_scheduler;
   logic CLOCK_50;
   logic reset;
   int   checks;
   int   failures;
   int   on_cnt;
   int   off_cnt;

   ps2_voice_if #(.NUM_VOICES(4)) bus ();

   ps2_voice_scheduler #(.NUM_VOICES(4)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Entered on a negedge; strobes one byte, returns on the next negedge with results visible.
   task automatic send(input logic [7:0] b);
      bus.ps2_key_data    = b;
      bus.ps2_key_pressed = 1'b1;
      @(negedge CLOCK_50);
      bus.ps2_key_pressed = 1'b0;
      on_cnt  += int'(bus.note_on);
      off_cnt += int'(bus.note_off);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      bus.ps2_key_pressed = 1'b0;
      reset = 1'b1;
      @(negedge CLOCK_50);
      reset = 1'b0;
      on_cnt  = 0;
      off_cnt = 0;
   endtask

   task automatic test_reset();
      @(negedge CLOCK_50);
      checks++; if (bus.voice_active !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", bus.voice_active); end
      checks++; if (bus.voice_key !== 32'h0) begin failures++; $display("FAIL reset_keys got=%h exp=00000000", bus.voice_key); end
      checks++; if (bus.note_on !== 1'b0 || bus.note_off !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", bus.note_on, bus.note_off); end
      checks++; if (bus.event_voice !== 3'd0 || bus.event_code !== 8'h00) begin failures++; $display("FAIL reset_event got=%0d/%h exp=0/00", bus.event_voice, bus.event_code); end
      checks++; if (bus.voices_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.voices_full); end
      reset = 1'b0;
   endtask

   task automatic test_make();
      do_reset();
      send(8'h1C);
      checks++; if (bus.note_on !== 1'b1 || bus.note_off !== 1'b0) begin failures++; $display("FAIL make_pulse got=%b%b exp=10", bus.note_on, bus.note_off); end
      checks++; if (bus.event_voice !== 3'd0 || bus.event_code !== 8'h1C) begin failures++; $display("FAIL make_event got=%0d/%h exp=0/1c", bus.event_voice, bus.event_code); end
      checks++; if (bus.voice_active !== 4'b0001) begin failures++; $display("FAIL make_active got=%b exp=0001", bus.voice_active); end
      @(negedge CLOCK_50);
      checks++; if (bus.note_on !== 1'b0 || bus.event_code !== 8'h1C) begin failures++; $display("FAIL make_hold got=%b/%h exp=0/1c", bus.note_on, bus.event_code); end
   endtask

   task automatic test_break_realloc();
      do_reset();
      send(8'h1C); send(8'h1B);
      checks++; if (bus.event_voice !== 3'd1 || bus.voice_key[15:8] !== 8'h1B) begin failures++; $display("FAIL second_voice got=%0d/%h exp=1/1b", bus.event_voice, bus.voice_key[15:8]); end
      send(8'hF0); send(8'h1C);
      checks++; if (bus.note_off !== 1'b1 || bus.note_on !== 1'b0) begin failures++; $display("FAIL break_pulse got=%b%b exp=01", bus.note_on, bus.note_off); end
      checks++; if (bus.event_voice !== 3'd0 || bus.event_code !== 8'h1C) begin failures++; $display("FAIL break_event got=%0d/%h exp=0/1c", bus.event_voice, bus.event_code); end
      checks++; if (bus.voice_active !== 4'b0010 || bus.voice_key[7:0] !== 8'h1C) begin failures++; $display("FAIL break_state got=%b/%h exp=0010/1c", bus.voice_active, bus.voice_key[7:0]); end
      send(8'h23);
      checks++; if (bus.note_on !== 1'b1 || bus.event_voice !== 3'd0 || bus.event_code !== 8'h23) begin failures++; $display("FAIL realloc_event got=%b/%0d/%h exp=1/0/23", bus.note_on, bus.event_voice, bus.event_code); end
      checks++; if (bus.voice_active !== 4'b0011) begin failures++; $display("FAIL realloc_active got=%b exp=0011", bus.voice_active); end
   endtask

   task automatic test_typematic();
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C);
      checks++; if (on_cnt !== 1 || off_cnt !== 0) begin failures++; $display("FAIL typematic_pulses got=%0d/%0d exp=1/0", on_cnt, off_cnt); end
      checks++; if (bus.voice_active !== 4'b0001) begin failures++; $display("FAIL typematic_active got=%b exp=0001", bus.voice_active); end
   endtask

   task automatic test_ignored();
      logic [7:0] seq [9];
      seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hFA, 8'hAA, 8'hF0, 8'h2B};
      do_reset();
      send(8'h1C);
      on_cnt = 0; off_cnt = 0;
      for (int i = 0; i < 9; i++) send(seq[i]);
      checks++; if (on_cnt !== 0 || off_cnt !== 0) begin failures++; $display("FAIL ignored_pulses got=%0d/%0d exp=0/0", on_cnt, off_cnt); end
      checks++; if (bus.voice_active !== 4'b0001) begin failures++; $display("FAIL ignored_active got=%b exp=0001", bus.voice_active); end
      send(8'h1B);
      checks++; if (bus.note_on !== 1'b1 || bus.event_voice !== 3'd1 || bus.event_code !== 8'h1B) begin failures++; $display("FAIL ignored_idle got=%b/%0d/%h exp=1/1/1b", bus.note_on, bus.event_voice, bus.event_code); end
   endtask

   task automatic test_full();
      do_reset();
      send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
      checks++; if (bus.voices_full !== 1'b1 || bus.voice_active !== 4'b1111) begin failures++; $display("FAIL full_state got=%b/%b exp=1/1111", bus.voices_full, bus.voice_active); end
      send(8'h34);
`ifdef VOICE_STEAL_EN
      checks++; if (bus.note_on !== 1'b1 || bus.note_off !== 1'b1) begin failures++; $display("FAIL steal_pulse got=%b%b exp=11", bus.note_on, bus.note_off); end
      checks++; if (bus.event_voice !== 3'd0 || bus.event_code !== 8'h34 || bus.voice_key !== 32'h2B231B34) begin failures++; $display("FAIL steal_state got=%0d/%h/%h exp=0/34/2b231b34", bus.event_voice, bus.event_code, bus.voice_key); end
      send(8'h33);
      checks++; if (bus.event_voice !== 3'd1 || bus.voice_key !== 32'h2B233334 || bus.voice_active !== 4'b1111) begin failures++; $display("FAIL steal_next got=%0d/%h/%b exp=1/2b233334/1111", bus.event_voice, bus.voice_key, bus.voice_active); end
`else
      checks++; if (bus.note_on !== 1'b0 || bus.note_off !== 1'b0) begin failures++; $display("FAIL drop_pulse got=%b%b exp=00", bus.note_on, bus.note_off); end
      checks++; if (bus.voice_key !== 32'h2B231B1C || bus.voices_full !== 1'b1 || bus.event_code !== 8'h2B) begin failures++; $display("FAIL drop_state got=%h/%b/%h exp=2b231b1c/1/2b", bus.voice_key, bus.voices_full, bus.event_code); end
      send(8'h33);
      checks++; if (bus.note_on !== 1'b0 || bus.event_voice !== 3'd3) begin failures++; $display("FAIL drop_next got=%b/%0d exp=0/3", bus.note_on, bus.event_voice); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h1C); send(8'h1B); send(8'h23); send(8'hF0);
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.voice_active !== 4'b0000 || bus.voice_key !== 32'h0 || bus.event_code !== 8'h00) begin failures++; $display("FAIL midreset_state got=%b/%h/%h exp=0000/00000000/00", bus.voice_active, bus.voice_key, bus.event_code); end
      @(negedge CLOCK_50);
      checks++; if (bus.note_off !== 1'b0 || bus.note_on !== 1'b0) begin failures++; $display("FAIL midreset_pulse got=%b%b exp=00", bus.note_on, bus.note_off); end
      reset = 1'b0;
      send(8'h1C);
      checks++; if (bus.note_on !== 1'b1 || bus.note_off !== 1'b0 || bus.event_voice !== 3'd0 || bus.voice_active !== 4'b0001) begin failures++; $display("FAIL midreset_make got=%b%b/%0d/%b exp=10/0/0001", bus.note_on, bus.note_off, bus.event_voice, bus.voice_active); end
   endtask

   initial begin
      checks              = 0;
      failures            = 0;
      on_cnt              = 0;
      off_cnt             = 0;
      reset               = 1'b1;
      bus.ps2_key_data    = 8'h00;
      bus.ps2_key_pressed = 1'b0;
      test_reset();
      test_make();
      test_break_realloc();
      test_typematic();
      test_ignored();
      test_full();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
